pio_edge_irq: RTL
=================

Name: pio_edge_irq

Overview:
Parametrised Avalon-MM slave PIO for the Nios II Qsys system, successor to the fixed 4-bit input-only PIO.
- Adds input synchronisation, a writable output port, per-bit edge capture and a maskable interrupt.
- Sits between Nios II data master (via interconnect) and board-level GPIO (keys, switches, LEDs); irq feeds the CPU IRQ receiver.

Parameters:
WIDTH, 8, number of in_port/out_port bits (1..32)
EDGE_TYPE, 0, edge that sets edgecapture bit: 0 rising, 1 falling, 2 any
IRQ_MODE, 0, 0 level (synchronised input & mask), 1 edge (edgecapture & mask)
OUT_RESET, 0, reset value of out_port register (WIDTH bits)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
address  input  2  word address of register
chipselect  input  1  slave select
write_n  input  1  active-low write strobe, valid with chipselect
writedata  input  32  write data; bits above WIDTH-1 ignored
readdata  output  32  registered read data, zero-extended above WIDTH
in_port  input  WIDTH  asynchronous external inputs
out_port  output  WIDTH  output data register
irq  output  1  interrupt request, active high

Behaviour:
- Reset (async, reset_n=0): readdata=0, out_port=OUT_RESET, sync1/sync2/sync3=0, irq_mask=0, edgecapture=0, irq=0. Every reset assertion, including mid-transfer, clears all state immediately; no pending write survives.
- Register map (address):
  - 0 data: read = sync2; write = out_port.
  - 1 reserved: reads 0, writes ignored.
  - 2 irq_mask: R/W, WIDTH bits.
  - 3 edgecapture: read = captured bits; write 1 to a bit clears it, 0 leaves it.
- Write accepted on any rising edge where chipselect=1 and write_n=0; takes effect that edge. No wait states.
- readdata <= mux(address) every clock, independent of chipselect/write_n (one-cycle read latency). Reads have no side effects.
- Input path: sync1 <= in_port, sync2 <= sync1, sync3 <= sync2, every cycle. in_port change stable before edge E1 reaches sync2 at E2; visible on readdata (address 0 held) at E3.
- Edge detect per bit, using sync2/sync3:
  - rising = sync2 & ~sync3
  - falling = ~sync2 & sync3
  - any = sync2 ^ sync3
- edgecapture bit sets at the next edge after detect (E3 for a change before E1). Sticky until cleared.
- Same cycle set and clear on one bit: set wins (bit stays 1). Clears of other bits still apply.
- irq is combinational from registers only (no path from bus inputs):
  - IRQ_MODE=0: irq = |(sync2 & irq_mask), asserted after E2.
  - IRQ_MODE=1: irq = |(edgecapture & irq_mask), asserted after E3.
- Writing irq_mask=0 deasserts irq the same cycle the write lands; edgecapture contents are unaffected.
- WIDTH=32: no zero-extension bits. WIDTH<32: readdata[31:WIDTH] always 0.

Test Plan:
1. Reset and idle: hold reset_n=0 with in_port=8'hFF -> readdata=0, out_port=8'h00, irq=0. Release; read addr 0 -> 32'h000000FF on the 3rd edge after release.
2. Output write: write addr 0 data 32'hDEADBEA5 -> out_port=8'hA5 next cycle. Read addr 0 still returns in_port, not out_port.
3. Rising edge capture, IRQ_MODE=1: mask=8'h01, in_port 0->1 on bit0 -> edgecapture=8'h01 at E3 and irq=1. Write addr 3 with 8'h01 -> edgecapture=0, irq=0. Pulse bit1 -> edgecapture=8'h02, irq stays 0.
4. Set/clear collision: time a write of 1 to addr 3 bit0 on the same edge a new bit0 rising edge is captured -> bit0 remains 1, irq stays 1.
5. Level mode, IRQ_MODE=0: mask=8'h80, in_port[7]=1 -> irq=1 from E2. in_port[7]=0 -> irq=0 two edges later. Writing mask=0 while input is high -> irq=0 immediately.
6. Async reset mid-operation: edgecapture=8'h0F, mask=8'hFF, irq=1; pulse reset_n low between edges -> all registers 0 and irq=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pio_edge_irq.sv
// Avalon-MM slave PIO with synchronised inputs, writable output register,
// per-bit edge capture and a maskable level/edge interrupt.
module pio_edge_irq #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      EDGE_TYPE = 0,
  parameter int unsigned      IRQ_MODE  = 0,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int unsigned DW     = 32;
  localparam logic [1:0]  A_DATA = 2'd0;
  localparam logic [1:0]  A_MASK = 2'd2;
  localparam logic [1:0]  A_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q, sync3_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [WIDTH-1:0] det_c, clr_c, wdata_c;
  logic             wr_c;

  assign wr_c    = chipselect & ~write_n;
  assign wdata_c = writedata[WIDTH-1:0];

  // Upper write-data bits carry no meaning when the port is narrower than the bus.
  if (WIDTH < DW) begin : g_wdata_hi
    logic wdata_hi_unused;
    assign wdata_hi_unused = ^writedata[DW-1:WIDTH];
  end

  // Per-bit edge detect on the two oldest synchroniser stages.
  always_comb begin
    det_c = '0;
    case (EDGE_TYPE)
      0:       det_c = sync2_q & ~sync3_q;
      1:       det_c = ~sync2_q & sync3_q;
      default: det_c = sync2_q ^ sync3_q;
    endcase
  end

  // Register writes; a capture on the same edge as a clear keeps the bit set.
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    clr_c  = '0;
    if (wr_c) begin
      case (address)
        A_DATA:  out_d  = wdata_c;
        A_MASK:  mask_d = wdata_c;
        A_EDGE:  clr_c  = wdata_c;
        default: ;
      endcase
    end
    edge_d = (edge_q & ~clr_c) | det_c;
  end

  // Read mux is sampled every cycle regardless of chipselect.
  always_comb begin
    rdata_d = '0;
    case (address)
      A_DATA:  rdata_d = DW'(sync2_q);
      A_MASK:  rdata_d = DW'(mask_q);
      A_EDGE:  rdata_d = DW'(edge_q);
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      out_q   <= OUT_RESET;
      mask_q  <= '0;
      edge_q  <= '0;
      rdata_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      out_q   <= out_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      rdata_q <= rdata_d;
    end
  end

  // Interrupt is formed only from registered state, never from bus inputs.
  if (IRQ_MODE == 1) begin : g_irq_edge
    assign irq = |(edge_q & mask_q);
  end else begin : g_irq_level
    assign irq = |(sync2_q & mask_q);
  end

  assign readdata = rdata_q;
  assign out_port = out_q;

endmodule
